if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Parametrised instruction-fetch stage with a prefetch FIFO. It decouples instruction memory from the decode stage: while the FIFO has space it streams sequential reads from memory, queues each {pc, instruction} pair, and hands them to ID through the give/get handshake. It sits between the instruction memory port and ID, and takes branch redirects from the execute side. A memory request, once issued, is held until memory completes it.

## Interface
Parameters:
- BITSIZE, 32, PC/address width
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- resetn_i  in  1  reset, asynchronous, active-low
- ID_IF_get_i  in  1  ID takes head entry this cycle (meaningful only while IF_ID_give_o=1)
- IF_ID_give_o  out  1  FIFO non-empty; head entry valid
- IF_ID_instr_o  out  32  head instruction
- IF_ID_pc_o  out  BITSIZE  head PC
- MEM_addr_o  out  BITSIZE  read address; stable while MEM_read_o=1
- MEM_read_o  out  1  read request
- MEM_data_i  in  32  read data, valid with MEM_valid_i
- MEM_valid_i  in  1  completes current request; may be asserted in the first request cycle
- pc_i  in  BITSIZE  redirect target
- branch_taken_i  in  1  one-cycle redirect strobe

## Operation
- Registered state: fsm ∈ {IDLE, REQ, DROP}; req_pc (drives MEM_addr_o); fetch_pc (next address); FIFO of FIFO_DEPTH × {BITSIZE pc, 32 instr}; count of width $clog2(FIFO_DEPTH)+1.
- MEM_read_o = (fsm≠IDLE). IF_ID_give_o = (count≠0). Head outputs are valid only while give=1.
- Completion = MEM_read_o & MEM_valid_i at a rising edge. Pop = give & ID_IF_get_i & ~branch_taken_i.
- space = (count after this edge's push/pop/flush) < FIFO_DEPTH.
- IDLE: on branch: fetch_pc←pc_i, flush, then →REQ with req_pc←pc_i. Otherwise, if space: →REQ with req_pc←fetch_pc.
- REQ, branch: flush FIFO. With completion, discard the data, req_pc←pc_i, stay REQ. Without completion, fetch_pc←pc_i, →DROP; the old request stays asserted.
- REQ, completion, no branch: push {req_pc, MEM_data_i}. fetch_pc←req_pc+4. If space, stay REQ with req_pc←req_pc+4 (back-to-back), else →IDLE.
- DROP: read stays high at the old address. A new branch overwrites fetch_pc with pc_i (last wins). Completion discards data; then req_pc←fetch_pc, or pc_i if a branch is present in that same cycle, and →REQ. The FIFO stays empty throughout DROP.
- Flush has priority over pop and push in the same cycle.
- Push+pop in the same cycle leaves count unchanged.
- REQ is only entered with a free slot, so push never overflows.
- Arithmetic: PC+4 wraps modulo 2^BITSIZE. pc_i is used unmodified, with no alignment check.

## Timing
- Reset (async assert): fsm=IDLE, MEM_read_o=0, MEM_addr_o=RESET_PC, fetch_pc=RESET_PC, count=0, IF_ID_give_o=0, IF_ID_instr_o=0, IF_ID_pc_o=0, FIFO pointers 0.
- Reset asserted mid-request abandons the request immediately.
- First edge after reset release: IDLE→REQ. MEM_read_o=1 with RESET_PC in cycle 1.
- Fetch latency: completion at edge N → give=1 from cycle N+1.
- Zero-wait memory (valid in every read cycle): 1 instruction/cycle sustained while ID pops every cycle.
- Redirect: branch at edge N from IDLE/REQ → MEM_addr_o=pc_i, read=1 in cycle N+1. From REQ without completion, pc_i is issued the cycle after the old request completes.
- Full FIFO with no pop: read drops to 0 on the edge that fills the last slot. It re-asserts the cycle after the next pop.

## Test plan
- Reset release, zero-wait memory returning data=addr, ID always gets → IF_ID_pc_o sequence 0,4,8,12…, one per cycle; instr matches pc.
- FIFO_DEPTH=4, ID_IF_get_i=0 → exactly 4 completions (pcs 0..12), then MEM_read_o=0. One get → a single read of 0x10 follows.
- Branch to 0x100 with 3 entries queued, memory zero-wait → give=0 next cycle, then next read addr 0x100, and the first delivered pc is 0x100.
- Memory with 3-cycle latency, branch to 0x200 in the first wait cycle of a read of 0x8 → addr holds 0x8 until valid, the 0x8 data is never delivered, then 0x200 is read.
- Two branches (0x300 then 0x400) during DROP → only 0x400 is fetched; no entry with pc 0x300 or the old address appears.
- BITSIZE=32, branch to 0xFFFFFFFC → delivered pcs 0xFFFFFFFC, 0x0; reset asserted mid-wait → read=0, give=0 immediately.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: streams sequential instruction reads into a small
// prefetch FIFO and hands {pc, instr} pairs to decode. A branch redirect
// flushes the FIFO; a read still in flight at redirect time is completed
// and its data thrown away before the new target is requested.
module if_prefetch_stage #(
    parameter int                 BITSIZE    = 32,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [BITSIZE-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               ID_IF_get_i,
    output logic               IF_ID_give_o,
    output logic [31:0]        IF_ID_instr_o,
    output logic [BITSIZE-1:0] IF_ID_pc_o,
    output logic [BITSIZE-1:0] MEM_addr_o,
    output logic               MEM_read_o,
    input  logic [31:0]        MEM_data_i,
    input  logic               MEM_valid_i,
    input  logic [BITSIZE-1:0] pc_i,
    input  logic               branch_taken_i
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // IDLE: no request (FIFO full); REQ: fetching for the FIFO;
    // DROP: waiting out a request made stale by a redirect.
    typedef enum logic [1:0] {IDLE, REQ, DROP} fsm_t;

    fsm_t               fsm, fsm_nxt;
    logic [BITSIZE-1:0] req_pc, req_pc_nxt;
    logic [BITSIZE-1:0] fetch_pc, fetch_pc_nxt;
    logic [BITSIZE-1:0] pc_mem    [FIFO_DEPTH];
    logic [31:0]        instr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               complete, pop, push, flush, space;

    // Sequential next address; wraps modulo 2^BITSIZE.
    function automatic logic [BITSIZE-1:0] pc_plus4(input logic [BITSIZE-1:0] pc);
        return pc + BITSIZE'(4);
    endfunction

    assign MEM_read_o    = (fsm != IDLE);
    assign MEM_addr_o    = req_pc;
    assign IF_ID_give_o  = (count != '0);
    // Head is forced to zero while empty so the outputs are clean out of reset
    // without resetting the storage array.
    assign IF_ID_pc_o    = IF_ID_give_o ? pc_mem[rd_ptr]    : '0;
    assign IF_ID_instr_o = IF_ID_give_o ? instr_mem[rd_ptr] : '0;

    // FIFO events this cycle and the occupancy they leave behind.
    always_comb begin
        complete = MEM_read_o & MEM_valid_i;
        flush    = branch_taken_i;
        pop      = IF_ID_give_o & ID_IF_get_i & ~branch_taken_i;
        push     = (fsm == REQ) & complete & ~branch_taken_i;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end
        space = (count_nxt < DEPTH_C);
    end

    // Fetch control: next state, next request address and next fetch address.
    always_comb begin
        fsm_nxt      = fsm;
        req_pc_nxt   = req_pc;
        fetch_pc_nxt = fetch_pc;
        case (fsm)
            IDLE: begin
                if (branch_taken_i) begin
                    fetch_pc_nxt = pc_i;
                    req_pc_nxt   = pc_i;
                    fsm_nxt      = REQ;
                end else if (space) begin
                    req_pc_nxt = fetch_pc;
                    fsm_nxt    = REQ;
                end
            end
            REQ: begin
                if (branch_taken_i) begin
                    fetch_pc_nxt = pc_i;
                    if (complete) begin
                        req_pc_nxt = pc_i;
                    end else begin
                        fsm_nxt = DROP;
                    end
                end else if (complete) begin
                    fetch_pc_nxt = pc_plus4(req_pc);
                    if (space) begin
                        req_pc_nxt = pc_plus4(req_pc);
                    end else begin
                        fsm_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (branch_taken_i) begin
                    fetch_pc_nxt = pc_i;
                end
                if (complete) begin
                    req_pc_nxt = branch_taken_i ? pc_i : fetch_pc;
                    fsm_nxt    = REQ;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Control state and FIFO bookkeeping; reset abandons any open request.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            fsm      <= IDLE;
            req_pc   <= RESET_PC;
            fetch_pc <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            fsm      <= fsm_nxt;
            req_pc   <= req_pc_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= MEM_data_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Testbench for if_prefetch_stage: directed scenarios plus randomized traffic,
// checked against an occupancy/expected-PC model of the instruction stream.
module tb_if_prefetch_stage;

    localparam int          BITSIZE = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        resetn, get, give, mem_read, mem_valid, branch;
    logic [31:0] instr, mem_data, pc_out, addr, pc_in;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: PC expected at the FIFO head, buffered entry count,
    // and whether the outstanding read was made stale by a redirect.
    logic [31:0] exp_pc;
    int          occ;
    bit          stale;
    int          lat, wcnt, n_comp;
    bit          rand_lat, noise;
    logic [31:0] deliv_q [$];

    if_prefetch_stage #(.BITSIZE(BITSIZE), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .resetn_i       (resetn),
        .ID_IF_get_i    (get),
        .IF_ID_give_o   (give),
        .IF_ID_instr_o  (instr),
        .IF_ID_pc_o     (pc_out),
        .MEM_addr_o     (addr),
        .MEM_read_o     (mem_read),
        .MEM_data_i     (mem_data),
        .MEM_valid_i    (mem_valid),
        .pc_i           (pc_in),
        .branch_taken_i (branch)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Instruction memory contents as a function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        get       = 1'b0;
        branch    = 1'b0;
        pc_in     = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        occ    = 0;
        exp_pc = RST_PC;
        stale  = 1'b0;
        wcnt   = 0;
        n_comp = 0;
        deliv_q.delete();
    endtask

    // One clock: drive inputs, advance the model, then check the DUT state.
    task automatic cycle(input bit g, input bit br, input logic [31:0] tgt);
        bit          v, comp, pop, pr;
        logic [31:0] pa;
        v         = mem_read && (wcnt >= lat);
        get       = g;
        branch    = br;
        pc_in     = tgt;
        mem_valid = mem_read ? v : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
        mem_data  = mem_word(addr);
        comp = mem_read && v;
        pop  = give && g && !br;
        pr   = mem_read;
        pa   = addr;
        if (comp) n_comp++;
        if (comp && !stale && !br) begin
            check("fetch_addr", addr, exp_pc + 32'(4 * occ));
            occ++;
        end
        if (pop) begin
            deliv_q.push_back(pc_out);
            occ--;
            exp_pc = exp_pc + 32'd4;
        end
        if (br) begin
            occ    = 0;
            exp_pc = tgt;
            stale  = mem_read && !v;
        end else if (comp) begin
            stale = 1'b0;
        end
        if (comp) begin
            wcnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end else if (mem_read) begin
            wcnt++;
        end
        @(posedge clk);
        #1;
        check("give", 32'(give), 32'(occ != 0));
        if (give) begin
            check("head_pc", pc_out, exp_pc);
            check("head_instr", instr, mem_word(exp_pc));
        end
        check("read", 32'(mem_read), 32'(occ < DEPTH));
        if (pr && !comp) check("addr_hold", addr, pa);
    endtask

    initial begin
        int bad, budget, gp;
        rand_lat = 1'b0;
        noise    = 1'b0;
        lat      = 0;

        // Reset values and zero-wait streaming with ID always taking.
        do_reset();
        check("rst_read", 32'(mem_read), 32'd0);
        check("rst_addr", addr, RST_PC);
        check("rst_give", 32'(give), 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instr, 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("first_read", 32'(mem_read), 32'd1);
        check("first_addr", addr, RST_PC);
        cycle(1'b1, 1'b0, '0);
        check("fetch_latency", 32'(give), 32'd1);
        repeat (9) cycle(1'b1, 1'b0, '0);
        check("stream_cnt", 32'(deliv_q.size()), 32'd9);
        for (int i = 0; i < deliv_q.size(); i++) check("stream_pc", deliv_q[i], 32'(4 * i));

        // No gets: exactly DEPTH reads complete, then a single pop frees one slot.
        do_reset();
        repeat (7) cycle(1'b0, 1'b0, '0);
        check("fill_comps", 32'(n_comp), 32'd4);
        check("fill_read", 32'(mem_read), 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("refill_read", 32'(mem_read), 32'd1);
        check("refill_addr", addr, 32'h10);
        cycle(1'b0, 1'b0, '0);
        check("refill_comps", 32'(n_comp), 32'd5);
        check("refill_stop", 32'(mem_read), 32'd0);

        // Branch with three entries queued, memory zero-wait.
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, '0);
        check("q3_give", 32'(give), 32'd1);
        cycle(1'b0, 1'b1, 32'h100);
        check("br_give", 32'(give), 32'd0);
        check("br_addr", addr, 32'h100);
        check("br_read", 32'(mem_read), 32'd1);
        deliv_q.delete();
        budget = 0;
        while (deliv_q.size() == 0 && budget < 10) begin
            cycle(1'b1, 1'b0, '0);
            budget++;
        end
        check("br_first_cnt", 32'(deliv_q.size() != 0), 32'd1);
        if (deliv_q.size() != 0) check("br_first_pc", deliv_q[0], 32'h100);

        // Three-wait memory: single and double redirect while a read of 0x8 waits.
        for (int two = 0; two < 2; two++) begin
            do_reset();
            lat = 3;
            budget = 0;
            while (!(mem_read && addr == 32'h8) && budget < 40) begin
                cycle(1'b1, 1'b0, '0);
                budget++;
            end
            check("reach_0x8", addr, 32'h8);
            deliv_q.delete();
            if (two == 0) begin
                cycle(1'b1, 1'b1, 32'h200);
            end else begin
                cycle(1'b1, 1'b1, 32'h300);
                cycle(1'b1, 1'b1, 32'h400);
            end
            budget = 0;
            while (addr == 32'h8 && budget < 10) begin
                cycle(1'b1, 1'b0, '0);
                budget++;
            end
            check("drop_target", addr, (two == 0) ? 32'h200 : 32'h400);
            repeat (12) cycle(1'b1, 1'b0, '0);
            bad = 0;
            foreach (deliv_q[i]) if (deliv_q[i] == 32'h8 || deliv_q[i] == 32'h300) bad++;
            check("no_stale_pc", 32'(bad), 32'd0);
            check("drop_deliv", 32'(deliv_q.size() != 0), 32'd1);
            if (deliv_q.size() != 0) check("drop_first_pc", deliv_q[0], (two == 0) ? 32'h200 : 32'h400);
        end

        // Address wrap from the top of the address space.
        do_reset();
        lat = 0;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        deliv_q.delete();
        repeat (8) cycle(1'b1, 1'b0, '0);
        check("wrap_cnt", 32'(deliv_q.size() >= 2), 32'd1);
        if (deliv_q.size() >= 2) begin
            check("wrap_pc0", deliv_q[0], 32'hFFFF_FFFC);
            check("wrap_pc1", deliv_q[1], 32'h0);
        end

        // Reset asserted while a read is waiting and entries are queued.
        do_reset();
        lat = 3;
        repeat (14) cycle(1'b0, 1'b0, '0);
        check("pre_rst_give", 32'(give), 32'd1);
        check("pre_rst_read", 32'(mem_read), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_read", 32'(mem_read), 32'd0);
        check("async_rst_give", 32'(give), 32'd0);
        check("async_rst_addr", addr, RST_PC);

        // Randomized traffic: random latency, gets, redirects and stray valids.
        do_reset();
        rand_lat = 1'b1;
        noise    = 1'b1;
        lat      = $urandom_range(0, 3);
        gp       = 70;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] t;
            if (c % 200 == 0) gp = (c % 600 == 0) ? 10 : ((c % 400 == 0) ? 100 : 70);
            t = $urandom;
            if ($urandom_range(0, 1) == 1) t = t & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 99) < gp, $urandom_range(0, 99) < 4, t);
        end
        check("rand_progress", 32'(deliv_q.size() > 300), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
